// File: rtl/decode_pkg.sv
// Shared types for the decode queue.
// Holds RV32I major opcodes, the micro-op class enum, the decoded micro-op
// record handed to rename/dispatch, and PC_W. PC_W is the tagged PC width and
// must equal the ROM_ADDR_WIDTH used by fetch and by decode_queue.
package decode_pkg;

  localparam int PC_W = 4;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd11
  } uop_class_e;

  typedef struct packed {
    uop_class_e        cls;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic              rd_we;
    logic              rs1_used;
    logic              rs2_used;
    logic [31:0]       imm;
    logic [PC_W-1:0]   pc;
    logic              illegal;
  } decoded_instr_t;

endpackage

// File: rtl/decode_queue_decoder.sv
// rv32i_decoder: purely combinational RV32I decoder.
// Ports:
//   instr_i  in  32    raw instruction word
//   pc_i     in  PC_W  tagged sequential PC, passed through
//   uop_o    out       decoded micro-op record
// Any encoding that is not a recognised RV32I major opcode, or an ALU
// register/shift-immediate form with a bad funct3/funct7 pairing, decodes
// to CLS_ILLEGAL with illegal=1, no register use and a zero immediate.
module rv32i_decoder
  import decode_pkg::*;
(
  input  logic [31:0]     instr_i,
  input  logic [PC_W-1:0] pc_i,
  output decoded_instr_t  uop_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  uop_class_e  cls;
  logic        writes, use1, use2;
  logic [31:0] imm;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  always_comb begin
    cls    = CLS_ILLEGAL;
    writes = 1'b0;
    use1   = 1'b0;
    use2   = 1'b0;
    imm    = '0;
    // Legal opcodes all end in 2'b11, so a bad low-bit pair falls to default.
    case (opcode)
      OPC_OP: begin
        // Only ADD/SRL may carry funct7=0x20 (SUB/SRA); everything else needs 0.
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          cls = CLS_ALU_R; writes = 1'b1; use1 = 1'b1; use2 = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // SLLI needs funct7=0; SRLI/SRAI allow 0 or 0x20.
        if (!((f3 == 3'd1 && f7 != 7'h00) ||
              (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))) begin
          cls = CLS_ALU_I; writes = 1'b1; use1 = 1'b1; imm = imm_i;
        end
      end
      OPC_LOAD:     begin cls = CLS_LOAD;   writes = 1'b1; use1 = 1'b1; imm = imm_i; end
      OPC_STORE:    begin cls = CLS_STORE;  use1 = 1'b1; use2 = 1'b1; imm = imm_s; end
      OPC_BRANCH:   begin cls = CLS_BRANCH; use1 = 1'b1; use2 = 1'b1; imm = imm_b; end
      OPC_JAL:      begin cls = CLS_JAL;    writes = 1'b1; imm = imm_j; end
      OPC_JALR:     begin cls = CLS_JALR;   writes = 1'b1; use1 = 1'b1; imm = imm_i; end
      OPC_LUI:      begin cls = CLS_LUI;    writes = 1'b1; imm = imm_u; end
      OPC_AUIPC:    begin cls = CLS_AUIPC;  writes = 1'b1; imm = imm_u; end
      OPC_MISC_MEM: begin cls = CLS_FENCE;  imm = imm_i; end
      OPC_SYSTEM: begin
        cls = CLS_SYSTEM; writes = 1'b1; imm = imm_i;
        // CSRRW/CSRRS/CSRRC read rs1; the immediate CSR forms do not.
        use1 = (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3);
      end
      default: cls = CLS_ILLEGAL;
    endcase

    uop_o          = '0;
    uop_o.cls      = cls;
    uop_o.rd       = instr_i[11:7];
    uop_o.rs1      = instr_i[19:15];
    uop_o.rs2      = instr_i[24:20];
    uop_o.funct3   = f3;
    uop_o.funct7b5 = instr_i[30];
    uop_o.rd_we    = writes && (instr_i[11:7] != 5'd0);
    uop_o.rs1_used = use1;
    uop_o.rs2_used = use2;
    uop_o.imm      = imm;
    uop_o.pc       = pc_i;
    uop_o.illegal  = (cls == CLS_ILLEGAL);
  end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: instruction FIFO between fetch and rename/dispatch.
// Tags each accepted word with a sequential PC and decodes the head entry.
// Ports:
//   clock, reset (sync, active-high)
//   fetch_instruction/fetch_valid  in   word from fetch
//   stall                          out  back-pressure, high when FIFO full
//   flush/flush_pc                 in   discard contents, restart PC tagging
//   dec_valid/dec_ready            out/in  head micro-op handshake
//   dec_uop                        out  decoded head entry
// Optional: define DECODE_QUEUE_STATS_EN to add stall_cycles and uops_issued
// (32-bit saturating counters cleared only by reset).
module decode_queue
  import decode_pkg::*;
#(
  parameter int ROM_ADDR_WIDTH = PC_W,
  parameter int DEPTH          = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               fetch_instruction,
  input  logic                      fetch_valid,
  output logic                      stall,
  input  logic                      flush,
  input  logic [ROM_ADDR_WIDTH-1:0] flush_pc,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output decoded_instr_t            dec_uop
`ifdef DECODE_QUEUE_STATS_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               uops_issued
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]               instr_q [DEPTH];
  logic [ROM_ADDR_WIDTH-1:0] pc_q    [DEPTH];

  logic [PTR_W:0]            count_q,  count_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [ROM_ADDR_WIDTH-1:0] seq_pc_q, seq_pc_d;
  logic                      push, pop;

  // stall depends on the registered count only, never on dec_ready.
  assign stall     = (count_q == (PTR_W+1)'(DEPTH));
  assign dec_valid = (count_q != '0) && !flush;
  assign push      = fetch_valid && !stall && !flush;
  assign pop       = dec_valid && dec_ready;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    seq_pc_d = seq_pc_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      seq_pc_d = flush_pc;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        seq_pc_d = seq_pc_q + ROM_ADDR_WIDTH'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      seq_pc_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      seq_pc_q <= seq_pc_d;
    end
  end

  // Storage is cleared on reset so the head decode is never X.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= fetch_instruction;
      pc_q[wr_ptr_q]    <= seq_pc_q;
    end
  end

  rv32i_decoder u_dec (
    .instr_i (instr_q[rd_ptr_q]),
    .pc_i    (pc_q[rd_ptr_q]),
    .uop_o   (dec_uop)
  );

`ifdef DECODE_QUEUE_STATS_EN
  logic [31:0] stall_cycles_q, uops_issued_q;

  // Counters survive flush; only reset clears them. Both stick at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
      uops_issued_q  <= '0;
    end else begin
      if (stall && fetch_valid && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (pop && (uops_issued_q != '1))
        uops_issued_q <= uops_issued_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign uops_issued  = uops_issued_q;
`endif

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
  import decode_pkg::*;

  localparam int DEPTH = 4;

  logic           clock;
  logic           reset;
  logic [31:0]    fetch_instruction;
  logic           fetch_valid;
  logic           stall;
  logic           flush;
  logic [3:0]     flush_pc;
  logic           dec_valid;
  logic           dec_ready;
  decoded_instr_t dec_uop;
`ifdef DECODE_QUEUE_STATS_EN
  logic [31:0]    stall_cycles, uops_issued;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of accepted words with their PC tags.
  logic [31:0] m_ins[$];
  int          m_pc[$];
  int          m_seq;

  decode_queue #(.ROM_ADDR_WIDTH(4), .DEPTH(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .fetch_instruction (fetch_instruction),
    .fetch_valid       (fetch_valid),
    .stall             (stall),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .dec_valid         (dec_valid),
    .dec_ready         (dec_ready),
    .dec_uop           (dec_uop)
`ifdef DECODE_QUEUE_STATS_EN
    ,
    .stall_cycles      (stall_cycles),
    .uops_issued       (uops_issued)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---- reference decode (ISA level) ----
  function automatic uop_class_e exp_cls(input logic [31:0] w);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    case (w[6:0])
      OPC_OP:
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) return CLS_ALU_R;
        else return CLS_ILLEGAL;
      OPC_OP_IMM:
        if (f3 == 3'd1 && f7 != 7'h00) return CLS_ILLEGAL;
        else if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return CLS_ILLEGAL;
        else return CLS_ALU_I;
      OPC_LOAD:     return CLS_LOAD;
      OPC_STORE:    return CLS_STORE;
      OPC_BRANCH:   return CLS_BRANCH;
      OPC_JAL:      return CLS_JAL;
      OPC_JALR:     return CLS_JALR;
      OPC_LUI:      return CLS_LUI;
      OPC_AUIPC:    return CLS_AUIPC;
      OPC_MISC_MEM: return CLS_FENCE;
      OPC_SYSTEM:   return CLS_SYSTEM;
      default:      return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] w);
    logic signed [11:0] s12;
    logic signed [12:0] s13;
    logic signed [20:0] s21;
    int v;
    case (exp_cls(w))
      CLS_ALU_I, CLS_LOAD, CLS_JALR, CLS_FENCE, CLS_SYSTEM: begin
        s12 = w[31:20]; v = s12; return v;
      end
      CLS_STORE: begin s12 = {w[31:25], w[11:7]}; v = s12; return v; end
      CLS_BRANCH: begin
        s13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; v = s13; return v;
      end
      CLS_LUI, CLS_AUIPC: return w & 32'hFFFFF000;
      CLS_JAL: begin
        s21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; v = s21; return v;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_we(input logic [31:0] w);
    uop_class_e c;
    c = exp_cls(w);
    if (c == CLS_STORE || c == CLS_BRANCH || c == CLS_FENCE || c == CLS_ILLEGAL) return 1'b0;
    return (w[11:7] != 5'd0);
  endfunction

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    bit          fl, psh, pp;
    logic [31:0] w;
    int          fpc;
    fl  = flush;
    fpc = flush_pc;
    w   = fetch_instruction;
    psh = fetch_valid && (m_ins.size() != DEPTH) && !fl;
    pp  = (m_ins.size() != 0) && !fl && dec_ready;
    @(posedge clock);
    #1;
    if (reset) begin
      m_ins.delete(); m_pc.delete(); m_seq = 0;
    end else if (fl) begin
      m_ins.delete(); m_pc.delete(); m_seq = fpc;
    end else begin
      if (pp) begin void'(m_ins.pop_front()); void'(m_pc.pop_front()); end
      if (psh) begin
        m_ins.push_back(w); m_pc.push_back(m_seq);
        m_seq = (m_seq + 1) % 16;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_valid = 1'b1; fetch_instruction = 32'h00500093;
    flush = 1'b1; flush_pc = 4'h5; dec_ready = 1'b1;
    tick(); tick();
    reset = 1'b0; flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_tests++;
    if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
    n_tests++;
    if ($isunknown(dec_uop)) begin n_fail++; $display("FAIL reset_uop_known: got %h expected no X", dec_uop); end
    // reset beats the simultaneous flush: first tag is 0, not 5
    fetch_valid = 1'b1; tick(); fetch_valid = 1'b0; #1;
    n_tests++;
    if (dec_valid !== 1'b1 || dec_uop.pc !== 4'h0) begin
      n_fail++; $display("FAIL reset_over_flush_pc: got v=%b pc=%h expected v=1 pc=0", dec_valid, dec_uop.pc);
    end
  endtask

  task automatic test_addi();
    do_reset();
    dec_ready = 1'b1; fetch_valid = 1'b1; fetch_instruction = 32'h00500093;
    #1;
    n_tests++;
    if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL addi_no_bypass: got %b expected 0", dec_valid); end
    tick();
    fetch_valid = 1'b0; #1;
    n_tests++;
    if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b expected 1", dec_valid); end
    n_tests++;
    if (dec_uop.cls !== CLS_ALU_I) begin n_fail++; $display("FAIL addi_class: got %0d expected %0d", dec_uop.cls, CLS_ALU_I); end
    n_tests++;
    if (dec_uop.rd !== 5'd1 || dec_uop.rs1 !== 5'd0) begin
      n_fail++; $display("FAIL addi_regs: got rd=%0d rs1=%0d expected rd=1 rs1=0", dec_uop.rd, dec_uop.rs1);
    end
    n_tests++;
    if (dec_uop.imm !== 32'd5 || dec_uop.rd_we !== 1'b1 || dec_uop.pc !== 4'h0) begin
      n_fail++; $display("FAIL addi_fields: got imm=%h we=%b pc=%h expected 5 1 0", dec_uop.imm, dec_uop.rd_we, dec_uop.pc);
    end
    tick(); #1;
    n_tests++;
    if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL addi_popped: got %b expected 0", dec_valid); end
  endtask

  task automatic test_stall();
    int npop;
    bit acc;
    do_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fetch_valid = 1'b1;
      fetch_instruction = 32'h00000093 | (32'(i) << 20);
      #1;
      n_tests++;
      if (stall !== (i == 4)) begin n_fail++; $display("FAIL stall_fill_%0d: got %b expected %b", i, stall, (i == 4)); end
      tick();
    end
    dec_ready = 1'b1; #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_no_comb_ready: got %b expected 1", stall); end
    npop = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) begin
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_drop: got %b expected 0", stall); end
      end
      if (dec_valid) begin
        n_tests++;
        if (dec_uop.pc !== 4'(npop) || dec_uop.imm !== 32'(npop)) begin
          n_fail++; $display("FAIL stall_order_%0d: got pc=%h imm=%h expected %h", npop, dec_uop.pc, dec_uop.imm, npop);
        end
        npop++;
      end
      acc = fetch_valid && !stall;
      tick();
      if (acc) fetch_valid = 1'b0;
      #1;
    end
    n_tests++;
    if (npop != 5) begin n_fail++; $display("FAIL stall_pop_count: got %0d expected 5", npop); end
  endtask

  task automatic test_branch();
    do_reset();
    flush = 1'b1; flush_pc = 4'h7; tick(); flush = 1'b0;
    fetch_valid = 1'b1; fetch_instruction = 32'hFE000EE3; tick();
    fetch_valid = 1'b0; #1;
    n_tests++;
    if (dec_valid !== 1'b1 || dec_uop.cls !== CLS_BRANCH || dec_uop.pc !== 4'h7) begin
      n_fail++; $display("FAIL beq_class_pc: got v=%b cls=%0d pc=%h expected 1 %0d 7", dec_valid, dec_uop.cls, dec_uop.pc, CLS_BRANCH);
    end
    n_tests++;
    if (dec_uop.imm !== 32'hFFFFFFFC || dec_uop.rd_we !== 1'b0) begin
      n_fail++; $display("FAIL beq_imm_we: got imm=%h we=%b expected fffffffc 0", dec_uop.imm, dec_uop.rd_we);
    end
    n_tests++;
    if (dec_uop.rs1_used !== 1'b1 || dec_uop.rs2_used !== 1'b1) begin
      n_fail++; $display("FAIL beq_used: got %b%b expected 11", dec_uop.rs1_used, dec_uop.rs2_used);
    end
  endtask

  task automatic test_flush();
    do_reset();
    dec_ready = 1'b0; fetch_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin fetch_instruction = 32'h00100093; tick(); end
    flush = 1'b1; flush_pc = 4'hA; fetch_instruction = 32'h00700093; dec_ready = 1'b1;
    #1;
    n_tests++;
    if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_low: got %b expected 0", dec_valid); end
    tick();
    flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0; #1;
    n_tests++;
    if (dec_valid !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_empty: got v=%b stall=%b expected 0 0", dec_valid, stall);
    end
    fetch_valid = 1'b1; tick(); fetch_valid = 1'b0; #1;
    n_tests++;
    if (dec_valid !== 1'b1 || dec_uop.pc !== 4'hA || dec_uop.imm !== 32'd7) begin
      n_fail++; $display("FAIL flush_pc: got v=%b pc=%h imm=%h expected 1 a 7", dec_valid, dec_uop.pc, dec_uop.imm);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    dec_ready = 1'b1; fetch_valid = 1'b1; fetch_instruction = 32'hFFFFFFFF; tick();
    fetch_instruction = 32'h40001033; #1;
    n_tests++;
    if (dec_uop.cls !== CLS_ILLEGAL || dec_uop.illegal !== 1'b1 || dec_uop.rd_we !== 1'b0) begin
      n_fail++; $display("FAIL illegal_ones: got cls=%0d ill=%b we=%b expected %0d 1 0", dec_uop.cls, dec_uop.illegal, dec_uop.rd_we, CLS_ILLEGAL);
    end
    tick(); fetch_valid = 1'b0; #1;
    n_tests++;
    if (dec_valid !== 1'b1 || dec_uop.illegal !== 1'b1 || dec_uop.cls !== CLS_ILLEGAL) begin
      n_fail++; $display("FAIL illegal_sll_f7: got v=%b ill=%b cls=%0d expected 1 1 %0d", dec_valid, dec_uop.illegal, dec_uop.cls, CLS_ILLEGAL);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    dec_ready = 1'b0; fetch_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin fetch_instruction = 32'h00000093 | (32'(i) << 20); tick(); end
    dec_ready = 1'b1; fetch_instruction = 32'h00300093; #1;
    n_tests++;
    if (dec_valid !== 1'b1 || dec_uop.pc !== 4'h0) begin
      n_fail++; $display("FAIL b2b_head: got v=%b pc=%h expected 1 0", dec_valid, dec_uop.pc);
    end
    tick(); #1;
    n_tests++;
    if (stall !== 1'b0 || dec_uop.pc !== 4'h1) begin
      n_fail++; $display("FAIL b2b_count3: got stall=%b pc=%h expected 0 1", stall, dec_uop.pc);
    end
    dec_ready = 1'b0; fetch_instruction = 32'h00400093; tick(); fetch_valid = 1'b0; #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_then_full: got %b expected 1", stall); end
    flush = 1'b1; flush_pc = 4'hF; tick(); flush = 1'b0;
    fetch_valid = 1'b1; tick(); tick(); fetch_valid = 1'b0; dec_ready = 1'b1; #1;
    n_tests++;
    if (dec_uop.pc !== 4'hF) begin n_fail++; $display("FAIL wrap_pc_f: got %h expected f", dec_uop.pc); end
    tick(); #1;
    n_tests++;
    if (dec_valid !== 1'b1 || dec_uop.pc !== 4'h0) begin
      n_fail++; $display("FAIL wrap_pc_0: got v=%b pc=%h expected 1 0", dec_valid, dec_uop.pc);
    end
    tick();
  endtask

  task automatic test_random();
    logic [6:0]  opc [11];
    logic [31:0] w;
    logic [31:0] h;
    opc = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
            OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_MISC_MEM, OPC_SYSTEM};
    do_reset();
    for (int c = 0; c < 400; c++) begin
      w = $urandom;
      if ($urandom_range(3) != 0) w[6:0] = opc[$urandom_range(10)];
      if ($urandom_range(1) == 0) w[31:25] = ($urandom_range(1) == 0) ? 7'h00 : 7'h20;
      fetch_instruction = w;
      fetch_valid = ($urandom_range(9) < 7);
      dec_ready   = ($urandom_range(9) < 6);
      flush       = ($urandom_range(19) == 0);
      flush_pc    = 4'($urandom);
      #1;
      n_tests++;
      if (stall !== (m_ins.size() == DEPTH)) begin
        n_fail++; $display("FAIL rnd_stall c%0d: got %b expected %b", c, stall, (m_ins.size() == DEPTH));
      end
      n_tests++;
      if (dec_valid !== ((m_ins.size() != 0) && !flush)) begin
        n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, dec_valid, ((m_ins.size() != 0) && !flush));
      end
      if (m_ins.size() != 0) begin
        h = m_ins[0];
        n_tests++;
        if (dec_uop.pc !== 4'(m_pc[0]) || dec_uop.cls !== exp_cls(h) || dec_uop.rd !== h[11:7]) begin
          n_fail++; $display("FAIL rnd_head c%0d: got pc=%h cls=%0d rd=%0d expected pc=%h cls=%0d rd=%0d (w=%h)",
                             c, dec_uop.pc, dec_uop.cls, dec_uop.rd, m_pc[0], exp_cls(h), h[11:7], h);
        end
        n_tests++;
        if (dec_uop.imm !== exp_imm(h) || dec_uop.rd_we !== exp_we(h) ||
            dec_uop.illegal !== (exp_cls(h) == CLS_ILLEGAL)) begin
          n_fail++; $display("FAIL rnd_fields c%0d: got imm=%h we=%b ill=%b expected imm=%h we=%b ill=%b (w=%h)",
                             c, dec_uop.imm, dec_uop.rd_we, dec_uop.illegal, exp_imm(h), exp_we(h),
                             (exp_cls(h) == CLS_ILLEGAL), h);
        end
      end
      tick();
    end
    flush = 1'b0; fetch_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_instruction = '0; fetch_valid = 1'b0;
    flush = 1'b0; flush_pc = '0; dec_ready = 1'b0; m_seq = 0;
    test_reset();
    test_addi();
    test_stall();
    test_branch();
    test_flush();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
